// File: rtl/cpu_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fetch_unit_if
// Brief    : Signal bundle for the CPU fetch unit. It groups the memory bus,
//            the load/store handshake, the prefetch queue head and the halt
//            and statistics signals.
//            master = fetch unit side, slave = memory/pipeline side.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_fetch_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  // memory bus
  logic [ADDR_WIDTH-1:0] address_bus;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  r;
  logic                  w;
  // branch redirect
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  // load/store handshake
  logic                  ls_req;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_done;
  logic [DATA_WIDTH-1:0] ls_rdata;
  // prefetch queue head
  logic                  q_valid;
  logic [DATA_WIDTH-1:0] q_data;
  logic [ADDR_WIDTH-1:0] q_pc;
  logic                  q_pop;
  // halt and statistics
  logic                  halt_req;
  logic                  halted;
  logic [15:0]           stall_count;

  modport master (
    output address_bus, data_out, r, w,
    input  data_in,
    input  redirect, redirect_pc,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    output ls_done, ls_rdata,
    output q_valid, q_data, q_pc,
    input  q_pop,
    input  halt_req,
    output halted, stall_count
  );

  modport slave (
    input  address_bus, data_out, r, w,
    output data_in,
    output redirect, redirect_pc,
    output ls_req, ls_we, ls_addr, ls_wdata,
    input  ls_done, ls_rdata,
    input  q_valid, q_data, q_pc,
    output q_pop,
    output halt_req,
    input  halted, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : cpu_fetch_unit
// Brief    : Fetch front-end. It owns the PC and a DEPTH-entry prefetch queue.
//            It arbitrates the single memory bus between instruction fetches
//            and execute-stage load/store requests, with load/store taking
//            priority. Each access holds its strobe for 1+WAIT_STATES cycles.
//            Optional macro CPU_FETCH_STATS_EN enables the stall_count counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_fetch_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH       = 4,
  parameter int RESET_PC    = 'h2000,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                reset,
  cpu_fetch_unit_if.master    bus
);

  localparam int                    c_PW       = $clog2(DEPTH);
  localparam int                    c_CW       = c_PW + 1;
  localparam logic [c_CW-1:0]       c_DEPTH    = c_CW'(DEPTH);
  localparam logic [2:0]            c_WS       = 3'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LS    = 2'd2
  } state_t;

  state_t                r_state, w_state_next;
  logic [2:0]            r_wait;
  logic [ADDR_WIDTH-1:0] r_pc, r_addr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rd_stb, r_wr_stb, r_ls_we;
  logic                  r_ls_done;
  logic [DATA_WIDTH-1:0] r_ls_rdata;
  logic                  r_halted;

  logic [DATA_WIDTH-1:0] r_qd [DEPTH];
  logic [ADDR_WIDTH-1:0] r_qa [DEPTH];
  logic [c_PW-1:0]       r_rd_ptr, r_wr_ptr;
  logic [c_CW-1:0]       r_count;
  logic [DATA_WIDTH-1:0] r_head_data;
  logic [ADDR_WIDTH-1:0] r_head_pc;

  logic                  w_last, w_fetch_ok;
  logic                  w_issue_fetch, w_issue_ls, w_fetch_done, w_ls_done;
  logic                  w_push, w_pop;
  logic [c_PW-1:0]       w_rd_next;
  logic [c_CW-1:0]       w_remain;

  // The FSM only issues from IDLE, so nothing is in flight when the queue
  // occupancy is tested; count alone covers count + in-flight.
  assign w_last     = (r_wait == c_WS);
  assign w_fetch_ok = (r_count < c_DEPTH) && !bus.halt_req && !bus.redirect;

  // Bus state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and issue/complete decode; a redirect cancels only fetches
  always_comb begin
    w_state_next  = r_state;
    w_issue_fetch = 1'b0;
    w_issue_ls    = 1'b0;
    w_fetch_done  = 1'b0;
    w_ls_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // ls_req is still held during the ls_done cycle, so it is ignored there
        if (bus.ls_req && !r_ls_done) begin
          w_issue_ls   = 1'b1;
          w_state_next = S_LS;
        end else if (w_fetch_ok) begin
          w_issue_fetch = 1'b1;
          w_state_next  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.redirect) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_fetch_done = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_LS: begin
        if (w_last) begin
          w_ls_done    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus address/strobe/write-data registers and the wait-state counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_dout   <= '0;
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      r_ls_we  <= 1'b0;
      r_wait   <= '0;
    end else if (w_issue_fetch) begin
      r_addr   <= r_pc;
      r_rd_stb <= 1'b1;
      r_wr_stb <= 1'b0;
      r_wait   <= '0;
    end else if (w_issue_ls) begin
      r_addr   <= bus.ls_addr;
      r_rd_stb <= !bus.ls_we;
      r_wr_stb <= bus.ls_we;
      r_ls_we  <= bus.ls_we;
      r_wait   <= '0;
      if (bus.ls_we) r_dout <= bus.ls_wdata;
    end else if (r_state != S_IDLE) begin
      if (w_state_next == S_IDLE) begin
        r_rd_stb <= 1'b0;
        r_wr_stb <= 1'b0;
      end else begin
        r_wait <= r_wait + 3'd1;
      end
    end
  end

  // Load/store completion pulse and captured load data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ls_done  <= 1'b0;
      r_ls_rdata <= '0;
    end else begin
      r_ls_done <= w_ls_done;
      if (w_ls_done && !r_ls_we) r_ls_rdata <= bus.data_in;
    end
  end

  // Queue bookkeeping: a redirect flushes and beats both push and pop
  assign w_push    = w_fetch_done;
  assign w_pop     = bus.q_pop && (r_count != '0) && !bus.redirect;
  assign w_rd_next = r_rd_ptr + c_PW'(w_pop);
  assign w_remain  = r_count - c_CW'(w_pop);

  // Queue storage, written with the fetched word and its address
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_qd[r_wr_ptr] <= bus.data_in;
      r_qa[r_wr_ptr] <= r_addr;
    end
  end

  // PC, pointers, count and the registered head (held while the queue is empty)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= c_RESET_PC;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_data <= '0;
      r_head_pc   <= '0;
    end else if (bus.redirect) begin
      r_pc     <= bus.redirect_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
        r_pc     <= r_pc + ADDR_WIDTH'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_remain + c_CW'(w_push);
      if (w_remain != '0) begin
        r_head_data <= r_qd[w_rd_next];
        r_head_pc   <= r_qa[w_rd_next];
      end else if (w_push) begin
        r_head_data <= bus.data_in;
        r_head_pc   <= r_addr;
      end
    end
  end

  // Halted once halt is requested and the bus will be idle
  always_ff @(posedge clk) begin
    if (reset) r_halted <= 1'b0;
    else       r_halted <= bus.halt_req && (w_state_next == S_IDLE);
  end

`ifdef CPU_FETCH_STATS_EN
  logic [15:0] r_stall_count;

  // Saturating count of cycles with no instruction available while running
  always_ff @(posedge clk) begin
    if (reset)
      r_stall_count <= '0;
    else if ((r_count == '0) && !r_halted && (r_stall_count != 16'hFFFF))
      r_stall_count <= r_stall_count + 16'd1;
  end
  assign bus.stall_count = r_stall_count;
`else
  assign bus.stall_count = 16'd0;
`endif

  assign bus.address_bus = r_addr;
  assign bus.data_out    = r_dout;
  assign bus.r           = r_rd_stb;
  assign bus.w           = r_wr_stb;
  assign bus.ls_done     = r_ls_done;
  assign bus.ls_rdata    = r_ls_rdata;
  assign bus.q_valid     = (r_count != '0);
  assign bus.q_data      = r_head_data;
  assign bus.q_pc        = r_head_pc;
  assign bus.halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_fetch_unit
// Brief    : Directed self-checking bench for cpu_fetch_unit. u_dut0 runs with
//            zero wait states and u_dut2 with two. Memory returns
//            address[7:0], except at 'h1F00, which returns 'hA5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef CPU_FETCH_STATS_EN
  localparam logic [15:0] c_STALL0 = 16'd2;
  localparam logic [15:0] c_STALL2 = 16'd4;
`else
  localparam logic [15:0] c_STALL0 = 16'd0;
  localparam logic [15:0] c_STALL2 = 16'd0;
`endif

  cpu_fetch_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) u_if0 ();
  cpu_fetch_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) u_if2 ();

  cpu_fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(4), .RESET_PC('h2000), .WAIT_STATES(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(u_if0));
  cpu_fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .DEPTH(4), .RESET_PC('h2000), .WAIT_STATES(2))
    u_dut2 (.clk(clk), .reset(reset), .bus(u_if2));

  assign u_if0.data_in = (u_if0.address_bus == 16'h1F00) ? 8'hA5 : u_if0.address_bus[7:0];
  assign u_if2.data_in = (u_if2.address_bus == 16'h1F00) ? 8'hA5 : u_if2.address_bus[7:0];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt;
    int          got;
    logic [15:0] pcs [4];
    logic [7:0]  dat [4];
    logic [15:0] stall_a;

    u_if0.redirect = 0; u_if0.redirect_pc = '0; u_if0.ls_req = 0; u_if0.ls_we = 0;
    u_if0.ls_addr = '0; u_if0.ls_wdata = '0; u_if0.q_pop = 0; u_if0.halt_req = 0;
    u_if2.redirect = 0; u_if2.redirect_pc = '0; u_if2.ls_req = 0; u_if2.ls_we = 0;
    u_if2.ls_addr = '0; u_if2.ls_wdata = '0; u_if2.q_pop = 0; u_if2.halt_req = 0;

    // ---- reset state ----
    reset = 1'b1;
    tick();
    chk("rst_addr", u_if0.address_bus, 16'h0000);
    chk("rst_rw", {u_if0.r, u_if0.w}, 2'b00);
    chk("rst_dout", u_if0.data_out, 8'h00);
    chk("rst_ls", {u_if0.ls_done, u_if0.ls_rdata}, 9'h000);
    chk("rst_qv_halt", {u_if0.q_valid, u_if0.halted}, 2'b00);
    chk("rst_stall", u_if0.stall_count, 16'h0000);
    tick();
    reset = 1'b0;

    // ---- test 1: first fetch, fill queue, stop ----
    tick();
    chk("t1_r_first", u_if0.r, 1'b1);
    chk("t1_addr_first", u_if0.address_bus, 16'h2000);
    tick();
    chk("t1_qv", u_if0.q_valid, 1'b1);
    chk("t1_qdata", u_if0.q_data, 8'h00);
    chk("t1_qpc", u_if0.q_pc, 16'h2000);
    chk("t1_r_low", u_if0.r, 1'b0);
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (u_if0.r) cnt++;
    end
    chk("t1_more_fetches", cnt, 3);
    chk("t1_r_stays_0", u_if0.r, 1'b0);
    chk("t1_qpc_kept", u_if0.q_pc, 16'h2000);
    chk("t1_stall0", u_if0.stall_count, c_STALL0);
    chk("t1_stall2", u_if2.stall_count, c_STALL2);

    // ---- test 2: load with queue full ----
    u_if0.ls_req = 1; u_if0.ls_we = 0; u_if0.ls_addr = 16'h1F00;
    tick();
    chk("t2_r", {u_if0.r, u_if0.w}, 2'b10);
    chk("t2_addr", u_if0.address_bus, 16'h1F00);
    chk("t2_done_early", u_if0.ls_done, 1'b0);
    tick();
    chk("t2_done", u_if0.ls_done, 1'b1);
    chk("t2_rdata", u_if0.ls_rdata, 8'hA5);
    chk("t2_r_drop", u_if0.r, 1'b0);
    u_if0.ls_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_no_fetch", {u_if0.r, u_if0.ls_done}, 2'b00);
    end

    // ---- test 3: redirect cancels in-flight fetch of 'h2002 ----
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    chk("t3_inflight_addr", u_if0.address_bus, 16'h2002);
    chk("t3_inflight_r", u_if0.r, 1'b1);
    u_if0.redirect = 1; u_if0.redirect_pc = 16'h3000;
    tick();
    u_if0.redirect = 0;
    chk("t3_flush_qv", u_if0.q_valid, 1'b0);
    chk("t3_cancel_r", u_if0.r, 1'b0);
    tick();
    chk("t3_refetch_r", u_if0.r, 1'b1);
    chk("t3_refetch_addr", u_if0.address_bus, 16'h3000);
    tick();
    chk("t3_head_pc", u_if0.q_pc, 16'h3000);
    chk("t3_head_qv", u_if0.q_valid, 1'b1);

    // ---- test 4: PC wrap with continuous pop ----
    u_if0.redirect = 1; u_if0.redirect_pc = 16'hFFFE;
    tick();
    u_if0.redirect = 0;
    u_if0.q_pop = 1;
    chk("t4_flush", u_if0.q_valid, 1'b0);
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      tick();
      if (u_if0.q_valid) begin
        pcs[got] = u_if0.q_pc;
        dat[got] = u_if0.q_data;
        got++;
      end
    end
    u_if0.q_pop = 0;
    chk("t4_count", got, 4);
    if (got == 4) begin
      chk("t4_pc0", pcs[0], 16'hFFFE);
      chk("t4_pc1", pcs[1], 16'hFFFF);
      chk("t4_pc2", pcs[2], 16'h0000);
      chk("t4_pc3", pcs[3], 16'h0001);
      chk("t4_d0", dat[0], 8'hFE);
      chk("t4_d2", dat[2], 8'h00);
    end

    // ---- test 5: store with 2 wait states (u_dut2 queue full by now) ----
    repeat (20) tick();
    chk("t5_idle", {u_if2.r, u_if2.w}, 2'b00);
    u_if2.ls_req = 1; u_if2.ls_we = 1; u_if2.ls_addr = 16'h0100; u_if2.ls_wdata = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_strobe", {u_if2.r, u_if2.w}, 2'b01);
      chk("t5_addr", u_if2.address_bus, 16'h0100);
      chk("t5_dout", u_if2.data_out, 8'h5A);
      chk("t5_not_done", u_if2.ls_done, 1'b0);
    end
    tick();
    chk("t5_done", u_if2.ls_done, 1'b1);
    chk("t5_strobe_off", {u_if2.r, u_if2.w}, 2'b00);
    chk("t5_rdata_kept", u_if2.ls_rdata, 8'h00);
    u_if2.ls_req = 0;
    tick();
    chk("t5_done_pulse", u_if2.ls_done, 1'b0);

    // ---- test 6: halt during a fetch ----
    u_if0.redirect = 1; u_if0.redirect_pc = 16'h2000;
    tick();
    u_if0.redirect = 0;
    tick();
    chk("t6_fetch_r", u_if0.r, 1'b1);
    chk("t6_fetch_addr", u_if0.address_bus, 16'h2000);
    u_if0.halt_req = 1;
    tick();
    chk("t6_halted", u_if0.halted, 1'b1);
    chk("t6_r_off", u_if0.r, 1'b0);
    chk("t6_qpc", u_if0.q_pc, 16'h2000);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (u_if0.r || !u_if0.halted) cnt++;
    end
    chk("t6_stay_halted", cnt, 0);
    chk("t6_queue_kept", u_if0.q_valid, 1'b1);
    u_if0.q_pop = 1;
    tick();
    u_if0.q_pop = 0;
    chk("t6_drained", u_if0.q_valid, 1'b0);
    stall_a = u_if0.stall_count;
    repeat (5) tick();
`ifdef CPU_FETCH_STATS_EN
    chk("t6_stall_frozen", u_if0.stall_count - stall_a, 16'd0);
`else
    chk("t6_stall_zero", u_if0.stall_count | stall_a, 16'd0);
`endif
    u_if0.halt_req = 0;
    tick();
    chk("t6_unhalt", u_if0.halted, 1'b0);
    chk("t6_resume_r", u_if0.r, 1'b1);
    chk("t6_resume_addr", u_if0.address_bus, 16'h2001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
